// File: rtl/sys_arr_pkg.sv
// Shared types and sizing for the systolic-array controller.
// Holds the FSM state encoding, default dimensions and the array pipeline latency.
package sys_arr_pkg;

    typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_e;

    localparam int DEF_WIDTH_HEIGHT = 2;
    localparam int DEF_ADDR_WIDTH   = 8;

    // Cycles from the first active cycle to the first valid output row.
    function automatic int latency(input int wh);
        return 2 * wh - 1;
    endfunction

endpackage

// File: rtl/sys_arr_out_seq.sv
// Delayed result-write sequencer: after a launch pulse it waits out the array latency,
// then raises out_wr_en for num_vecs cycles while out_addr counts up and saturates.
module sys_arr_out_seq
    import sys_arr_pkg::*;
#(
    parameter int width_height = DEF_WIDTH_HEIGHT,
    parameter int addr_width   = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  launch,
    input  logic [addr_width-1:0] num_vecs,
    output logic                  out_wr_en,
    output logic [addr_width-1:0] out_addr,
    output logic                  last
);

    localparam int LAT = latency(width_height);

    logic [LAT-1:0]        launch_q, launch_d;
    logic                  en_q, en_d;
    logic [addr_width-1:0] addr_q, addr_d;

    assign last      = en_q && (addr_q == num_vecs - addr_width'(1));
    assign out_wr_en = en_q;
    assign out_addr  = addr_q;

    always_comb begin
        launch_d = LAT'({launch_q, launch});
        en_d     = en_q;
        addr_d   = addr_q;
        if (clear) begin
            launch_d = '0;
            en_d     = 1'b0;
            addr_d   = '0;
        end else if (launch_q[LAT-1]) begin
            en_d   = 1'b1;
            addr_d = '0;
        end else if (last) begin
            // address is left on its final value until the controller goes idle
            en_d = 1'b0;
        end else if (en_q) begin
            addr_d = addr_q + addr_width'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            launch_q <= '0;
            en_q     <= 1'b0;
            addr_q   <= '0;
        end else begin
            launch_q <= launch_d;
            en_q     <= en_d;
            addr_q   <= addr_d;
        end
    end

endmodule

// File: rtl/sys_arr_ctrl.sv
// Systolic-array job controller: loads weights, streams input vectors, and hands the
// delayed result window to sys_arr_out_seq. All outputs come straight from flops.
module sys_arr_ctrl
    import sys_arr_pkg::*;
#(
    parameter int width_height = DEF_WIDTH_HEIGHT,
    parameter int addr_width   = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [addr_width-1:0] num_vecs,
    output logic                  wwrite,
    output logic [addr_width-1:0] w_addr,
    output logic                  active,
    output logic [addr_width-1:0] d_addr,
    output logic                  out_wr_en,
    output logic [addr_width-1:0] out_addr,
    output logic                  busy,
    output logic                  done
);

    localparam logic [addr_width-1:0] W_LAST = addr_width'(width_height - 1);

    state_e                state_q, state_d;
    logic [addr_width-1:0] nv_q, nv_d;
    logic [addr_width-1:0] w_addr_q, w_addr_d;
    logic [addr_width-1:0] d_addr_q, d_addr_d;
    logic                  wwrite_q, wwrite_d;
    logic                  active_q, active_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  launch, seq_last, seq_clear;

    always_comb begin
        state_d  = state_q;
        nv_d     = nv_q;
        w_addr_d = w_addr_q;
        d_addr_d = d_addr_q;
        wwrite_d = 1'b0;
        active_d = 1'b0;
        done_d   = 1'b0;
        launch   = 1'b0;
        if (abort) begin
            state_d  = IDLE;
            w_addr_d = '0;
            d_addr_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    w_addr_d = '0;
                    d_addr_d = '0;
                    if (start) begin
                        state_d  = LOAD_W;
                        nv_d     = num_vecs;
                        wwrite_d = 1'b1;
                    end
                end
                LOAD_W: begin
                    if (w_addr_q == W_LAST) begin
                        if (nv_q == '0) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d  = STREAM;
                            active_d = 1'b1;
                            launch   = 1'b1;
                        end
                    end else begin
                        wwrite_d = 1'b1;
                        w_addr_d = w_addr_q + addr_width'(1);
                    end
                end
                STREAM: begin
                    if (d_addr_q == nv_q - addr_width'(1)) begin
                        state_d = DRAIN;
                    end else begin
                        active_d = 1'b1;
                        d_addr_d = d_addr_q + addr_width'(1);
                    end
                end
                DRAIN: begin
                    if (seq_last) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
                DONE: begin
                    state_d  = IDLE;
                    w_addr_d = '0;
                    d_addr_d = '0;
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    // Output sequencer is flushed whenever the controller is heading to IDLE.
    assign seq_clear = (state_d == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            nv_q     <= '0;
            w_addr_q <= '0;
            d_addr_q <= '0;
            wwrite_q <= 1'b0;
            active_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            nv_q     <= nv_d;
            w_addr_q <= w_addr_d;
            d_addr_q <= d_addr_d;
            wwrite_q <= wwrite_d;
            active_q <= active_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    sys_arr_out_seq #(
        .width_height(width_height),
        .addr_width  (addr_width)
    ) u_out_seq (
        .clk      (clk),
        .reset    (reset),
        .clear    (seq_clear),
        .launch   (launch),
        .num_vecs (nv_q),
        .out_wr_en(out_wr_en),
        .out_addr (out_addr),
        .last     (seq_last)
    );

    assign wwrite = wwrite_q;
    assign w_addr = w_addr_q;
    assign active = active_q;
    assign d_addr = d_addr_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
